// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and port identifiers for the memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; on conflict the port that did not win last time wins.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);
  assign gnt_o[0] = req_i[0] & (~req_i[1] | last_grant_i);
  assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_grant_i);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port memory between fetch (port 0) and load/store (port 1).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  output logic                  p0_resp_valid,
  input  logic                  p0_resp_ready,
  output logic [DATA_WIDTH-1:0] p0_resp_rdata,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata,
  output logic                  p1_resp_valid,
  input  logic                  p1_resp_ready,
  output logic [DATA_WIDTH-1:0] p1_resp_rdata,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);
  state_e                state_q, state_d;
  logic                  owner_q, owner_d, last_q, last_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]            gnt;

  rr_arbiter2 u_rr (
    .req_i        ({p1_req_valid, p0_req_valid}),
    .last_grant_i (last_q),
    .gnt_o        (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= PORT_FETCH;
      last_q  <= PORT_DATA;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mem_write = 1'b0;
    case (state_q)
      IDLE: if (|gnt) begin
        owner_d = gnt[1];
        last_d  = gnt[1];
        we_d    = gnt[1] & p1_req_we;
        addr_d  = gnt[1] ? p1_req_addr : p0_req_addr;
        wdata_d = gnt[1] ? p1_req_wdata : '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        mem_write = we_q;
        rdata_d   = we_q ? '0 : mem_rdata;
        state_d   = RESP;
      end
      RESP: state_d = (owner_q ? p1_resp_ready : p0_resp_ready) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // Readies are gated by rst_n so nothing is offered while reset is held.
  assign p0_req_ready  = rst_n && state_q == IDLE && gnt[0];
  assign p1_req_ready  = rst_n && state_q == IDLE && gnt[1];
  assign p0_resp_valid = state_q == RESP && owner_q == PORT_FETCH;
  assign p1_resp_valid = state_q == RESP && owner_q == PORT_DATA;
  assign p0_resp_rdata = rdata_q;
  assign p1_resp_rdata = rdata_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign busy          = state_q != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, backpressure and reset against a memory model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        p0_req_valid, p0_req_ready, p0_resp_valid, p0_resp_ready;
  logic [4:0]  p0_req_addr, p1_req_addr, mem_addr;
  logic [31:0] p0_resp_rdata, p1_req_wdata, p1_resp_rdata, mem_wdata, mem_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_we, p1_resp_valid, p1_resp_ready;
  logic        mem_write, busy;
  logic [31:0] mem [32] = '{5: 32'hDEADBEEF, 7: 32'h00000077, default: 32'h0};
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_addr(p0_req_addr),
    .p0_resp_valid(p0_resp_valid), .p0_resp_ready(p0_resp_ready), .p0_resp_rdata(p0_resp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_resp_valid(p1_resp_valid), .p1_resp_ready(p1_resp_ready), .p1_resp_rdata(p1_resp_rdata),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  initial begin
    p0_req_valid = 1; p0_req_addr = 5; p0_resp_ready = 1;
    p1_req_valid = 1; p1_req_addr = 7; p1_req_we = 0; p1_req_wdata = 0; p1_resp_ready = 1;
    repeat (2) step();
    chk("rst_p0_ready", 32'(p0_req_ready), 0);
    chk("rst_p1_ready", 32'(p1_req_ready), 0);
    chk("rst_p0_rvalid", 32'(p0_resp_valid), 0);
    chk("rst_p1_rvalid", 32'(p1_resp_valid), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("conf%0d_p0_ready", k), 32'(p0_req_ready), 32'(k % 2 == 0));
      chk($sformatf("conf%0d_p1_ready", k), 32'(p1_req_ready), 32'(k % 2 == 1));
      step();
      chk($sformatf("conf%0d_busy", k), 32'(busy), 1);
      chk($sformatf("conf%0d_mem_write", k), 32'(mem_write), 0);
      step();
      chk($sformatf("conf%0d_p0_rvalid", k), 32'(p0_resp_valid), 32'(k % 2 == 0));
      chk($sformatf("conf%0d_p1_rvalid", k), 32'(p1_resp_valid), 32'(k % 2 == 1));
      chk($sformatf("conf%0d_rdata", k), (k % 2 == 1) ? p1_resp_rdata : p0_resp_rdata,
          (k % 2 == 1) ? 32'h77 : 32'hDEADBEEF);
      step();
    end
    p0_req_valid = 0; p1_req_valid = 0;
    #1;
    chk("idle_busy", 32'(busy), 0);

    p1_req_valid = 1; p1_req_we = 0; p1_req_addr = 5;
    #1;
    chk("load_ready", 32'(p1_req_ready), 1);
    step();
    p1_req_valid = 0;
    chk("load_mem_write", 32'(mem_write), 0);
    chk("load_mem_addr", 32'(mem_addr), 5);
    step();
    chk("load_rvalid", 32'(p1_resp_valid), 1);
    chk("load_rdata", p1_resp_rdata, 32'hDEADBEEF);
    step();

    p1_req_valid = 1; p1_req_we = 1; p1_req_addr = 3; p1_req_wdata = 32'h12345678;
    #1;
    chk("store_ready", 32'(p1_req_ready), 1);
    chk("store_idle_mem_write", 32'(mem_write), 0);
    step();
    p1_req_valid = 0; p1_req_we = 0;
    chk("store_mem_write", 32'(mem_write), 1);
    chk("store_mem_addr", 32'(mem_addr), 3);
    chk("store_mem_wdata", mem_wdata, 32'h12345678);
    step();
    chk("store_resp_mem_write", 32'(mem_write), 0);
    chk("store_ack_valid", 32'(p1_resp_valid), 1);
    chk("store_ack_rdata", p1_resp_rdata, 0);
    step();
    p0_req_valid = 1; p0_req_addr = 3;
    #1;
    chk("fetch_ready", 32'(p0_req_ready), 1);
    step();
    p0_req_valid = 0;
    step();
    chk("fetch_rvalid", 32'(p0_resp_valid), 1);
    chk("fetch_rdata", p0_resp_rdata, 32'h12345678);
    step();

    p0_resp_ready = 0; p0_req_valid = 1; p0_req_addr = 5;
    #1;
    chk("bp_p0_ready", 32'(p0_req_ready), 1);
    step();
    p0_req_valid = 0; p1_req_valid = 1; p1_req_we = 0; p1_req_addr = 7;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_rvalid", i), 32'(p0_resp_valid), 1);
      chk($sformatf("bp%0d_rdata", i), p0_resp_rdata, 32'hDEADBEEF);
      chk($sformatf("bp%0d_p1_ready", i), 32'(p1_req_ready), 0);
      step();
    end
    p0_resp_ready = 1;
    #1;
    chk("bp_final_rvalid", 32'(p0_resp_valid), 1);
    step();
    chk("bp_after_p1_ready", 32'(p1_req_ready), 1);
    chk("bp_after_p0_rvalid", 32'(p0_resp_valid), 0);
    step();
    p1_req_valid = 0;
    step();
    chk("bp_p1_rdata", p1_resp_rdata, 32'h77);
    step();

    p1_resp_ready = 0; p1_req_valid = 1; p1_req_we = 1; p1_req_addr = 9; p1_req_wdata = 32'hAAAA5555;
    step();
    p1_req_valid = 0;
    step();
    chk("mid_resp_valid", 32'(p1_resp_valid), 1);
    rst_n = 0;
    #1;
    chk("mid_rst_rvalid", 32'(p1_resp_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rdata", p1_resp_rdata, 0);
    chk("mid_store_committed", mem[9], 32'hAAAA5555);
    step();
    rst_n = 1; p1_resp_ready = 1;
    p1_req_valid = 1; p1_req_we = 1; p1_req_addr = 7; p1_req_wdata = 32'hBAD0BAD0;
    #1;
    chk("abort_ready", 32'(p1_req_ready), 1);
    step();
    chk("abort_access_write", 32'(mem_write), 1);
    rst_n = 0; p1_req_valid = 0; p1_req_we = 0;
    #1;
    chk("abort_write_drop", 32'(mem_write), 0);
    step();
    chk("abort_mem7", mem[7], 32'h77);
    rst_n = 1;
    step();
    chk("abort_busy", 32'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
